// File: rtl/carregador_instrucoes_if.sv
// Byte-stream input, instruction-memory write port and load status of the boot loader.
// Both handshakes are strobe-only: byte_valido and mem_escrita are one-cycle pulses, no backpressure.
interface carregador_instrucoes_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  iniciar;
    logic                  byte_valido;
    logic [7:0]            byte_dado;
    logic                  mem_escrita;
    logic [15:0]           mem_endereco;
    logic [15:0]           mem_dado;
    logic                  reset_cpu;
    logic                  carregando;
    logic                  concluido;
    logic                  erro;
    logic [ADDR_WIDTH:0]   palavras_carregadas;

    modport master (
        input  iniciar, byte_valido, byte_dado,
        output mem_escrita, mem_endereco, mem_dado,
        output reset_cpu, carregando, concluido, erro, palavras_carregadas
    );

    modport slave (
        output iniciar, byte_valido, byte_dado,
        input  mem_escrita, mem_endereco, mem_dado,
        input  reset_cpu, carregando, concluido, erro, palavras_carregadas
    );
endinterface

// File: rtl/carregador_instrucoes.sv
// Boot loader: assembles a serial program image into 16-bit words, writes them to
// instruction memory and releases the core's reset only after a valid checksum.
module carregador_instrucoes #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CICLOS = 100000
) (
    input  logic                      clock,
    input  logic                      reset,
    carregador_instrucoes_if.master   bus,
    output logic [2:0]                estado
);
    typedef enum logic [2:0] {
        OCIOSO, CONT_ALTO, CONT_BAIXO, DADO_ALTO, DADO_BAIXO, CHECKSUM, CONCLUIDO, ERRO
    } estado_t;

    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [16:0]         MAX_PALAVRAS   = 17'(2 ** ADDR_WIDTH);
    localparam logic [TW-1:0]       TIMEOUT_ULTIMO = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0]       UM_T           = 1;
    localparam logic [ADDR_WIDTH-1:0] UM_I         = 1;
    localparam logic [ADDR_WIDTH:0] UM_P           = 1;

    estado_t                 estado_atual, estado_prox;
    logic [7:0]              contagem_alta;
    logic [15:0]             n_palavras;
    logic [7:0]              dado_alto;
    logic [ADDR_WIDTH-1:0]   indice;
    logic [7:0]              acumulador;
    logic [TW-1:0]           ocioso_cnt;

    logic        ativo, prox_ativo, partida, expirou, ha_mais, contagem_ok;
    logic [15:0] contagem_nova;

    assign estado        = estado_atual;
    assign ativo         = estado_atual inside {CONT_ALTO, CONT_BAIXO, DADO_ALTO, DADO_BAIXO, CHECKSUM};
    assign prox_ativo    = estado_prox inside {CONT_ALTO, CONT_BAIXO, DADO_ALTO, DADO_BAIXO, CHECKSUM};
    assign partida       = !ativo && bus.iniciar;
    assign expirou       = ativo && !bus.byte_valido && (ocioso_cnt == TIMEOUT_ULTIMO);
    assign ha_mais       = (17'(indice) + 17'd1) < {1'b0, n_palavras};
    assign contagem_nova = {contagem_alta, bus.byte_dado};
    assign contagem_ok   = (contagem_nova != 16'd0) && ({1'b0, contagem_nova} <= MAX_PALAVRAS);

    always_ff @(posedge clock) begin
        if (reset) estado_atual <= OCIOSO;
        else       estado_atual <= estado_prox;
    end

    always_comb begin
        estado_prox = estado_atual;
        case (estado_atual)
            OCIOSO, CONCLUIDO, ERRO: if (bus.iniciar)     estado_prox = CONT_ALTO;
            CONT_ALTO:               if (bus.byte_valido) estado_prox = CONT_BAIXO;
            CONT_BAIXO:              if (bus.byte_valido) estado_prox = contagem_ok ? DADO_ALTO : ERRO;
            DADO_ALTO:               if (bus.byte_valido) estado_prox = DADO_BAIXO;
            DADO_BAIXO:              if (bus.byte_valido) estado_prox = ha_mais ? DADO_ALTO : CHECKSUM;
            CHECKSUM:                if (bus.byte_valido)
                                         estado_prox = (bus.byte_dado == acumulador) ? CONCLUIDO : ERRO;
            default:                 estado_prox = OCIOSO;
        endcase
        if (expirou) estado_prox = ERRO;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.mem_escrita         <= 1'b0;
            bus.mem_endereco        <= 16'd0;
            bus.mem_dado            <= 16'd0;
            bus.reset_cpu           <= 1'b1;
            bus.carregando          <= 1'b0;
            bus.concluido           <= 1'b0;
            bus.erro                <= 1'b0;
            bus.palavras_carregadas <= '0;
            contagem_alta           <= 8'd0;
            n_palavras              <= 16'd0;
            dado_alto               <= 8'd0;
            indice                  <= '0;
            acumulador              <= 8'd0;
            ocioso_cnt              <= '0;
        end else begin
            // Status flags follow the next state so they change on the same edge as the FSM.
            bus.carregando  <= prox_ativo;
            bus.concluido   <= (estado_prox == CONCLUIDO);
            bus.erro        <= (estado_prox == ERRO);
            bus.reset_cpu   <= (estado_prox != CONCLUIDO);
            bus.mem_escrita <= 1'b0;

            if (partida) begin
                indice                  <= '0;
                bus.palavras_carregadas <= '0;
                acumulador              <= 8'd0;
                ocioso_cnt              <= '0;
            end else if (ativo) begin
                if (bus.byte_valido) begin
                    ocioso_cnt <= '0;
                    acumulador <= acumulador ^ bus.byte_dado;
                    case (estado_atual)
                        CONT_ALTO:  contagem_alta <= bus.byte_dado;
                        CONT_BAIXO: n_palavras    <= contagem_nova;
                        DADO_ALTO:  dado_alto     <= bus.byte_dado;
                        DADO_BAIXO: begin
                            bus.mem_escrita         <= 1'b1;
                            bus.mem_endereco        <= 16'({indice, 1'b0});
                            bus.mem_dado            <= {dado_alto, bus.byte_dado};
                            bus.palavras_carregadas <= bus.palavras_carregadas + UM_P;
                            // The last word keeps its index so it never exceeds N-1.
                            if (ha_mais) indice <= indice + UM_I;
                        end
                        default: ;
                    endcase
                end else begin
                    ocioso_cnt <= ocioso_cnt + UM_T;
                end
            end
        end
    end
endmodule

// File: tb/tb_carregador_instrucoes.sv
// Self-checking bench for carregador_instrucoes: randomized images checked against an
// image-level reference model and a write scoreboard.
module tb_carregador_instrucoes;
    localparam int AW = 8;
    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] estado;

    always #5 clock = ~clock;

    carregador_instrucoes_if #(.ADDR_WIDTH(AW)) bus ();

    carregador_instrucoes #(.ADDR_WIDTH(AW), .TIMEOUT_CICLOS(TO)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .estado (estado)
    );

    int total = 0;
    int bad = 0;
    int n_writes = 0;

    logic [7:0]  img_q[$];
    logic [31:0] exp_q[$];
    bit          exp_ok;
    int          exp_palavras;
    int          n_envio;

    // Scoreboard: every write cycle must match the next expected {address, word}.
    always @(negedge clock) begin
        if (bus.mem_escrita === 1'b1) begin
            logic [31:0] e;
            n_writes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                         bus.mem_endereco, bus.mem_dado);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_endereco, bus.mem_dado} !== e) begin
                    bad++;
                    $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_endereco, bus.mem_dado, e[31:16], e[15:0]);
                end
            end
        end
    end

    // Reference model: derives the expected writes and outcome from the image bytes alone.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_q.delete();
        n = {img_q[0], img_q[1]};
        if (n == 0 || n > (1 << AW)) begin
            exp_ok = 0;
            exp_palavras = 0;
            n_envio = 2;
        end else begin
            x = 8'd0;
            for (int i = 0; i < 2 + 2 * n; i++) x ^= img_q[i];
            for (int k = 0; k < n; k++)
                exp_q.push_back({16'(2 * k), img_q[2 + 2 * k], img_q[3 + 2 * k]});
            exp_ok = (img_q[2 + 2 * n] == x);
            exp_palavras = n;
            n_envio = 3 + 2 * n;
        end
    endtask

    task automatic make_image(input int n, input bit corrupt);
        logic [7:0] x, b;
        logic [15:0] nn;
        nn = 16'(n);
        img_q.delete();
        img_q.push_back(nn[15:8]);
        img_q.push_back(nn[7:0]);
        x = nn[15:8] ^ nn[7:0];
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            img_q.push_back(b);
            x ^= b;
        end
        img_q.push_back(corrupt ? (x ^ (8'h01 << $urandom_range(0, 7))) : x);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit ini);
        bus.byte_valido = 1'b1;
        bus.byte_dado   = b;
        bus.iniciar     = ini;
        tick();
        bus.byte_valido = 1'b0;
        bus.iniciar     = 1'b0;
        bus.byte_dado   = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic load_image(input string nome, input bit b2b, input bit mix_ini, input bit start_with_byte);
        model();
        bus.iniciar     = 1'b1;
        bus.byte_valido = start_with_byte;
        bus.byte_dado   = 8'hFF;
        tick();
        bus.iniciar     = 1'b0;
        bus.byte_valido = 1'b0;
        total++;
        if (bus.carregando !== 1'b1 || bus.reset_cpu !== 1'b1 || bus.concluido !== 1'b0 || bus.erro !== 1'b0) begin
            bad++;
            $display("FAIL %s_start: got carregando=%b reset_cpu=%b concluido=%b erro=%b, required 1 1 0 0",
                     nome, bus.carregando, bus.reset_cpu, bus.concluido, bus.erro);
        end
        for (int i = 0; i < n_envio; i++)
            send_byte(img_q[i], b2b ? 0 : $urandom_range(0, 3), mix_ini && (i > 0) && ($urandom_range(0, 1) == 1));
        total++;
        if (bus.carregando !== 1'b0 || bus.concluido !== exp_ok || bus.erro !== !exp_ok
            || bus.reset_cpu !== !exp_ok || bus.palavras_carregadas !== (AW + 1)'(exp_palavras)) begin
            bad++;
            $display("FAIL %s_end: got carregando=%b concluido=%b erro=%b reset_cpu=%b palavras=%0d, required 0 %b %b %b %0d",
                     nome, bus.carregando, bus.concluido, bus.erro, bus.reset_cpu, bus.palavras_carregadas,
                     exp_ok, !exp_ok, !exp_ok, exp_palavras);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_writes: got %0d pending, required 0", nome, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        total++;
        if (bus.reset_cpu !== 1'b1 || bus.mem_escrita !== 1'b0 || bus.mem_endereco !== 16'd0
            || bus.mem_dado !== 16'd0 || bus.carregando !== 1'b0 || bus.concluido !== 1'b0
            || bus.erro !== 1'b0 || bus.palavras_carregadas !== '0 || estado !== 3'd0) begin
            bad++;
            $display("FAIL reset_values: got reset_cpu=%b we=%b addr=%h data=%h carr=%b conc=%b erro=%b pal=%0d est=%0d, required 1 0 0 0 0 0 0 0 0",
                     bus.reset_cpu, bus.mem_escrita, bus.mem_endereco, bus.mem_dado, bus.carregando,
                     bus.concluido, bus.erro, bus.palavras_carregadas, estado);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        img_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        load_image("directed_ok", 1, 0, 0);
        img_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        load_image("directed_bad_checksum", 0, 0, 0);
    endtask

    task automatic test_bad_count();
        int w0;
        w0 = n_writes;
        img_q = '{8'h00, 8'h00};
        load_image("count_zero", 1, 0, 0);
        img_q = '{8'h01, 8'h01};
        load_image("count_257", 0, 0, 0);
        send_byte(8'h12, 0, 0);
        send_byte(8'h34, 2, 0);
        total++;
        if (n_writes != w0 || bus.erro !== 1'b1) begin
            bad++;
            $display("FAIL bad_count_no_write: got writes=%0d erro=%b, required 0 1", n_writes - w0, bus.erro);
        end
    endtask

    task automatic test_max_count();
        make_image(1 << AW, 0);
        load_image("count_max", 1, 0, 0);
    endtask

    task automatic test_timeout();
        int w0;
        img_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        model();
        exp_q.delete();
        w0 = n_writes;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(img_q[i], 0, 0);
        repeat (TO - 1) tick();
        total++;
        if (bus.erro !== 1'b0 || bus.carregando !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: got erro=%b carregando=%b after %0d idle, required 0 1", bus.erro, bus.carregando, TO - 1);
        end
        tick();
        total++;
        if (bus.erro !== 1'b1 || bus.carregando !== 1'b0 || bus.reset_cpu !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire: got erro=%b carregando=%b reset_cpu=%b, required 1 0 1", bus.erro, bus.carregando, bus.reset_cpu);
        end
        send_byte(8'h34, 0, 0);
        send_byte(8'h27, 2, 0);
        total++;
        if (bus.erro !== 1'b1 || n_writes != w0 || bus.palavras_carregadas !== '0) begin
            bad++;
            $display("FAIL timeout_ignore: got erro=%b writes=%0d palavras=%0d, required 1 0 0",
                     bus.erro, n_writes - w0, bus.palavras_carregadas);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        exp_q.delete();
        w0 = n_writes;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        send_byte(8'h00, 0, 0);
        send_byte(8'h01, 1, 0);
        send_byte(8'h12, 0, 0);
        bus.byte_valido = 1'b1;
        bus.byte_dado   = 8'h34;
        reset           = 1'b1;
        tick();
        bus.byte_valido = 1'b0;
        reset           = 1'b0;
        total++;
        if (bus.mem_escrita !== 1'b0 || bus.carregando !== 1'b0 || bus.reset_cpu !== 1'b1
            || bus.palavras_carregadas !== '0 || estado !== 3'd0) begin
            bad++;
            $display("FAIL reset_mid_load: got we=%b carr=%b reset_cpu=%b pal=%0d est=%0d, required 0 0 1 0 0",
                     bus.mem_escrita, bus.carregando, bus.reset_cpu, bus.palavras_carregadas, estado);
        end
        tick();
        total++;
        if (n_writes != w0) begin
            bad++;
            $display("FAIL reset_pending_write: got writes=%0d, required 0", n_writes - w0);
        end
        make_image(3, 0);
        load_image("reload_after_reset", 0, 0, 0);
    endtask

    task automatic test_restart();
        make_image(2, 0);
        load_image("first_load", 1, 0, 0);
        make_image(4, 0);
        load_image("restart_from_concluido", 0, 0, 0);
        make_image(2, 0);
        load_image("iniciar_with_byte", 0, 0, 1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            make_image($urandom_range(1, 6), $urandom_range(0, 3) == 0);
            load_image("random", $urandom_range(0, 1) == 1, 1, 0);
        end
    endtask

    initial begin
        bus.iniciar     = 1'b0;
        bus.byte_valido = 1'b0;
        bus.byte_dado   = 8'd0;
        test_reset();
        test_directed();
        test_bad_count();
        test_max_count();
        test_timeout();
        test_reset_mid_load();
        test_restart();
        test_random();
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/carregador_instrucoes.md
# carregador_instrucoes

Boot loader sitting directly upstream of the 16-bit single-cycle MIPS core and its instruction memory. Receives a program image as a byte stream from the serial receiver, assembles 16-bit instruction words, and writes them into instruction memory at PC-compatible byte addresses. Holds the core in reset until a complete image with a valid checksum has been loaded, then releases it.

## Interface

Parameters:
- ADDR_WIDTH, 8: word-index width; capacity 2^ADDR_WIDTH instruction words.
- TIMEOUT_CICLOS, 100000: maximum idle cycles between bytes during a load before aborting.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- iniciar  in  1  load request, single-cycle pulse.
- byte_valido  in  1  one-cycle strobe from the serial receiver; byte_dado valid.
- byte_dado  in  8  received byte.
- mem_escrita  out  1  one-cycle write enable to instruction memory.
- mem_endereco  out  16  write byte address, {word index, 1'b0} zero-extended.
- mem_dado  out  16  instruction word to write.
- reset_cpu  out  1  drives the core's reset; high except after a successful load.
- carregando  out  1  high while a load is in progress.
- concluido  out  1  high after a successful load.
- erro  out  1  high after a failed load.
- palavras_carregadas  out  ADDR_WIDTH+1  words written in the current or last load.

## Operation

- Image format, byte order: count high, count low (16-bit word count N), then N words each sent high byte first, then one checksum byte.
- Checksum: 8-bit XOR of all preceding bytes of the image (both count bytes and all data bytes).
- Valid N: 1 to 2^ADDR_WIDTH inclusive. Any other N → ERRO immediately after count low byte; no writes.
- States: OCIOSO, CONT_ALTO, CONT_BAIXO, DADO_ALTO, DADO_BAIXO, CHECKSUM, CONCLUIDO, ERRO.
- OCIOSO/CONCLUIDO/ERRO: iniciar → CONT_ALTO; clears word index, palavras_carregadas, XOR accumulator, timeout counter; drops concluido/erro. byte_valido ignored in these states. If iniciar and byte_valido coincide, the byte is discarded.
- CONT_ALTO → CONT_BAIXO → DADO_ALTO on each accepted byte.
- DADO_ALTO → DADO_BAIXO on byte; DADO_BAIXO on byte: issue write of {high, low} at index k, k+1 → palavras_carregadas; → DADO_ALTO if k+1 < N, else CHECKSUM.
- CHECKSUM on byte: equal to accumulator → CONCLUIDO, else → ERRO.
- iniciar ignored in CONT_ALTO through CHECKSUM.
- Timeout: in CONT_ALTO..CHECKSUM, counter increments each cycle without byte_valido, clears on each accepted byte; reaching TIMEOUT_CICLOS consecutive idle cycles → ERRO.
- Writes already issued are not undone on ERRO; core stays in reset.
- Word k is written at mem_endereco = 2k (matches PC step of 2). Index never exceeds N-1.

## Timing

- Reset values: state OCIOSO, reset_cpu=1, mem_escrita=0, mem_endereco=0, mem_dado=0, carregando=0, concluido=0, erro=0, palavras_carregadas=0.
- All outputs registered.
- Write latency: mem_escrita high for exactly the one cycle after the edge that accepts a low data byte; mem_endereco/mem_dado valid in that same cycle and held until the next write.
- carregando high from the edge accepting iniciar until the edge entering CONCLUIDO or ERRO.
- concluido=1 and reset_cpu=0 from the edge accepting a correct checksum byte; held until reset or next iniciar (reset_cpu returns to 1 on that same edge).
- erro=1 from the edge of the failing event (bad count, bad checksum, timeout); held until reset or iniciar.
- Back-to-back bytes (byte_valido every cycle) accepted without loss.
- reset mid-load: next edge returns to reset values; a pending write is not issued.

## Test plan

- Reset asserted 2 cycles → reset_cpu=1, all other outputs 0, state OCIOSO.
- iniciar, bytes 00 02 12 34 AB CD 42 → writes 0x1234 @0x0000 and 0xABCD @0x0002, one cycle each; concluido=1, reset_cpu=0, palavras_carregadas=2.
- Same image with checksum 43 → both writes occur, erro=1, concluido=0, reset_cpu=1.
- ADDR_WIDTH=8, counts 00 00 and 01 01 → erro=1 after count low byte, mem_escrita never asserted.
- TIMEOUT_CICLOS=16, image stops after first data byte → erro=1 after 16 idle cycles; byte_valido afterwards ignored.
- reset during DADO_BAIXO then full reload; also iniciar from CONCLUIDO → reset_cpu rises same edge, second image loads and completes.
